// File: rtl/seq_arith_unit.sv
// seq_arith_unit: handshaked arithmetic unit (ADD, SUB, CMP, unsigned MUL).
// ADD/SUB/CMP finish in one cycle; MUL is a shift-add loop, one multiplier
// bit per cycle. The multiplier is only built when SEQ_ARITH_MUL_EN is
// defined. Without it, opcode 10 completes in one cycle and flags illegal.
//
// Handshake: a request is accepted on a rising edge where in_valid and
// in_ready are both high. A result is retired on a rising edge where
// out_valid and out_ready are both high. in_ready is high only in IDLE.
// out_valid is high only in DONE. While DONE waits, every result output
// holds its value. The unit never accepts a request in the same cycle that
// it retires a result.
module seq_arith_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       opCode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CarryIN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_hi,
   output logic             CarryOUT,
   output logic             overflow,
   output logic             zero,
   output logic             negative,
   output logic             illegal,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic             accept;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic             add_ovf;
   logic             sub_ovf;

   assign accept    = in_valid && (state == IDLE);
   assign dbg_state = state;

   // Single-cycle results come straight from the live operands and are
   // captured at the accept edge.
   assign sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, CarryIN};
   assign diff    = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, CarryIN};
   assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
   assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

`ifdef SEQ_ARITH_MUL_EN
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic               mul_last;

   // One shift-add step: add A shifted by the bit index when that multiplier bit is set.
   always_comb begin
      acc_next = acc;
      if (b_q[cnt]) begin
         acc_next = acc + ({{WIDTH{1'b0}}, a_q} << cnt);
      end
   end

   assign mul_last = (cnt == CW'(WIDTH - 1));

   // Multiplier operand capture and iteration registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         a_q <= A;
         b_q <= B;
         cnt <= '0;
         acc <= '0;
      end else if (state == BUSY) begin
         acc <= acc_next;
         cnt <= cnt + CW'(1);
      end
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
`ifdef SEQ_ARITH_MUL_EN
               state_next = (opCode == 2'b10) ? BUSY : DONE;
`else
               state_next = DONE;
`endif
            end
         end
         BUSY: begin
`ifdef SEQ_ARITH_MUL_EN
            if (mul_last) begin
               state_next = DONE;
            end
`else
            state_next = IDLE;
`endif
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Result registers: loaded only on entry to DONE, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         Y        <= '0;
         Y_hi     <= '0;
         CarryOUT <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
         illegal  <= 1'b0;
      end else if (accept) begin
         case (opCode)
            2'b00: begin
               Y        <= sum[WIDTH-1:0];
               Y_hi     <= '0;
               CarryOUT <= sum[WIDTH];
               overflow <= add_ovf;
               zero     <= (sum[WIDTH-1:0] == '0);
               negative <= sum[WIDTH-1];
               illegal  <= 1'b0;
            end
            2'b01: begin
               Y        <= diff[WIDTH-1:0];
               Y_hi     <= '0;
               CarryOUT <= diff[WIDTH];
               overflow <= sub_ovf;
               zero     <= (diff[WIDTH-1:0] == '0);
               negative <= diff[WIDTH-1];
               illegal  <= 1'b0;
            end
            2'b11: begin
               Y        <= '0;
               Y_hi     <= '0;
               CarryOUT <= diff[WIDTH];
               overflow <= sub_ovf;
               zero     <= (diff[WIDTH-1:0] == '0);
               negative <= diff[WIDTH-1];
               illegal  <= 1'b0;
            end
            default: begin
`ifdef SEQ_ARITH_MUL_EN
               // MUL results are loaded when the iteration finishes.
`else
               Y        <= '0;
               Y_hi     <= '0;
               CarryOUT <= 1'b0;
               overflow <= 1'b0;
               zero     <= 1'b0;
               negative <= 1'b0;
               illegal  <= 1'b1;
`endif
            end
         endcase
`ifdef SEQ_ARITH_MUL_EN
      end else if ((state == BUSY) && mul_last) begin
         Y        <= acc_next[WIDTH-1:0];
         Y_hi     <= acc_next[2*WIDTH-1:WIDTH];
         CarryOUT <= 1'b0;
         overflow <= (acc_next[2*WIDTH-1:WIDTH] != '0);
         zero     <= (acc_next == '0);
         negative <= 1'b0;
         illegal  <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Testbench for seq_arith_unit (WIDTH=8). Expected results come from an
// integer-arithmetic reference model. Build with or without SEQ_ARITH_MUL_EN.
module tb_seq_arith_unit;

   localparam int W  = 8;
   localparam int RW = 2 * W + 5;
`ifdef SEQ_ARITH_MUL_EN
   localparam int MUL_LAT = W + 1;
`else
   localparam int MUL_LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   opCode = 2'b00;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         CarryIN = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] Y;
   logic [W-1:0] Y_hi;
   logic         CarryOUT;
   logic         overflow;
   logic         zero;
   logic         negative;
   logic         illegal;
   logic [1:0]   dbg_state;

   int errors = 0;
   int checks = 0;

   logic [RW-1:0] exp_q[$];

   seq_arith_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opCode(opCode), .A(A), .B(B), .CarryIN(CarryIN),
      .out_valid(out_valid), .out_ready(out_ready),
      .Y(Y), .Y_hi(Y_hi), .CarryOUT(CarryOUT), .overflow(overflow),
      .zero(zero), .negative(negative), .illegal(illegal),
      .dbg_state(dbg_state)
   );

   // Clock generation.
   always #5 clk = ~clk;

   function automatic logic [RW-1:0] pk(input logic [W-1:0] y, input logic [W-1:0] yh,
                                        input logic co, input logic ov, input logic z,
                                        input logic n, input logic il);
      return {y, yh, co, ov, z, n, il};
   endfunction

   function automatic logic [RW-1:0] observed();
      return {Y, Y_hi, CarryOUT, overflow, zero, negative, illegal};
   endfunction

   // Reference model: plain integer arithmetic on the operation's definition.
   function automatic logic [RW-1:0] model(input logic [1:0] op, input int a, input int b,
                                           input int cin);
      int sa, sb, r, sr, yv, hv;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      case (op)
         2'b00: begin
            r  = a + b + cin;
            sr = sa + sb + cin;
            yv = r % 256;
            return pk(W'(yv), '0, r > 255, (sr > 127) || (sr < -128), yv == 0, yv >= 128, 1'b0);
         end
         2'b01, 2'b11: begin
            r  = a - b - cin;
            sr = sa - sb - cin;
            yv = (r + 512) % 256;
            return pk((op == 2'b01) ? W'(yv) : '0, '0, a < b + cin,
                      (sr > 127) || (sr < -128), yv == 0, yv >= 128, 1'b0);
         end
         default: begin
`ifdef SEQ_ARITH_MUL_EN
            r  = a * b;
            yv = r % 256;
            hv = r / 256;
            return pk(W'(yv), W'(hv), 1'b0, hv != 0, r == 0, 1'b0, 1'b0);
`else
            hv = 0;
            return pk('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
         end
      endcase
   endfunction

   // Driver: present one request and hold it until the accept edge.
   task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
      int t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1; t++;
      end
      if (!in_ready) begin
         errors++;
         $display("FAIL send_wait: in_ready=%0b after %0d cycles, required 1", in_ready, t);
      end
      opCode = op; A = a; B = b; CarryIN = cin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Driver: count cycles from the accept edge until out_valid is seen.
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   // Driver: one retirement handshake.
   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_handshake: in_ready,out_valid=%b required 10", {in_ready, out_valid});
      end
      checks++;
      if (observed() !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required %h", observed(), {RW{1'b0}});
      end
   endtask

   task automatic test_directed();
      logic [1:0] op; logic [W-1:0] a, b; logic cin; logic [RW-1:0] ex; int el, lat, n;
`ifdef SEQ_ARITH_MUL_EN
      n = 7;
`else
      n = 6;
`endif
      for (int i = 0; i < n; i++) begin
         el = 1;
         case (i)
            0: begin op = 2'b00; a = 8'hFF; b = 8'h01; cin = 0; ex = pk(8'h00, 8'h00, 1, 0, 1, 0, 0); end
            1: begin op = 2'b01; a = 8'h80; b = 8'h01; cin = 0; ex = pk(8'h7F, 8'h00, 0, 1, 0, 0, 0); end
            2: begin op = 2'b11; a = 8'h05; b = 8'h05; cin = 0; ex = pk(8'h00, 8'h00, 0, 0, 1, 0, 0); end
            3: begin op = 2'b01; a = 8'h00; b = 8'h00; cin = 1; ex = pk(8'hFF, 8'h00, 1, 0, 0, 1, 0); end
            4: begin op = 2'b00; a = 8'h7F; b = 8'h00; cin = 1; ex = pk(8'h80, 8'h00, 0, 1, 0, 1, 0); end
`ifdef SEQ_ARITH_MUL_EN
            5: begin op = 2'b10; a = 8'h0F; b = 8'h11; cin = 0; ex = pk(8'hFF, 8'h00, 0, 0, 0, 0, 0); el = 9; end
            default: begin op = 2'b10; a = 8'hFF; b = 8'hFF; cin = 1; ex = pk(8'h01, 8'hFE, 0, 1, 0, 0, 0); el = 9; end
`else
            default: begin op = 2'b10; a = 8'h03; b = 8'h04; cin = 0; ex = pk(8'h00, 8'h00, 0, 0, 0, 0, 1); end
`endif
         endcase
         send(op, a, b, cin);
         wait_result(lat);
         checks++;
         if (lat !== el) begin
            errors++;
            $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, el);
         end
         checks++;
         if (observed() !== ex) begin
            errors++;
            $display("FAIL dir%0d_result: got %h required %h", i, observed(), ex);
         end
         retire();
         checks++;
         if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL dir%0d_retire: in_ready,out_valid=%b required 10", i, {in_ready, out_valid});
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] op; logic [W-1:0] a, b; logic cin; logic [RW-1:0] ex; int lat, el;
      for (int i = 0; i < 40; i++) begin
         op  = 2'($urandom_range(0, 3));
         a   = W'($urandom_range(0, 255));
         b   = W'($urandom_range(0, 255));
         cin = 1'($urandom_range(0, 1));
         exp_q.push_back(model(op, int'(a), int'(b), int'(cin)));
         el = (op == 2'b10) ? MUL_LAT : 1;
         send(op, a, b, cin);
         wait_result(lat);
         ex = exp_q.pop_front();
         checks++;
         if (lat !== el) begin
            errors++;
            $display("FAIL rand%0d_latency: op=%0d got %0d required %0d", i, op, lat, el);
         end
         checks++;
         if (observed() !== ex) begin
            errors++;
            $display("FAIL rand%0d_result: op=%0d a=%h b=%h cin=%0b got %h required %h",
                     i, op, a, b, cin, observed(), ex);
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         retire();
         checks++;
         if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rand%0d_retire: in_ready,out_valid=%b required 10", i, {in_ready, out_valid});
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [RW-1:0] ex; int lat;
      ex = model(2'b00, 8'h3C, 8'h5A, 1);
      send(2'b00, 8'h3C, 8'h5A, 1'b1);
      wait_result(lat);
      for (int i = 0; i < 3; i++) begin
         opCode = 2'b01; A = W'($urandom_range(0, 255)); B = W'($urandom_range(0, 255));
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         checks++;
         if ({in_ready, out_valid} !== 2'b01 || observed() !== ex) begin
            errors++;
            $display("FAIL bp_hold%0d: in_ready,out_valid=%b out=%h required 01 %h",
                     i, {in_ready, out_valid}, observed(), ex);
         end
      end
      retire();
      checks++;
      if ({in_ready, out_valid} !== 2'b10 || observed() !== ex) begin
         errors++;
         $display("FAIL bp_release: in_ready,out_valid=%b out=%h required 10 %h",
                  {in_ready, out_valid}, observed(), ex);
      end
   endtask

   task automatic test_reset_mid_mul();
      logic [RW-1:0] ex; int lat;
      send(2'b00, 8'h21, 8'h42, 1'b0);
      wait_result(lat);
      retire();
      send(2'b10, 8'hA5, 8'h7E, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b10 || observed() !== '0) begin
         errors++;
         $display("FAIL mid_reset: in_ready,out_valid=%b out=%h required 10 %h",
                  {in_ready, out_valid}, observed(), {RW{1'b0}});
      end
      ex = model(2'b00, 8'h12, 8'h34, 1);
      send(2'b00, 8'h12, 8'h34, 1'b1);
      wait_result(lat);
      checks++;
      if (lat !== 1 || observed() !== ex) begin
         errors++;
         $display("FAIL post_reset_add: lat=%0d out=%h required 1 %h", lat, observed(), ex);
      end
      retire();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_pressure();
      test_random();
      test_reset_mid_mul();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
